// File: rtl/fpga_regs_pkg.sv
// Shared constants and helpers for the board-control register bank.
package fpga_regs_pkg;

  localparam int unsigned MAX_REG_W = 32;
  localparam int unsigned MAX_REGS  = 16;
  // Byte counter / read pointer width; covers up to four bytes per register.
  localparam int unsigned CNT_W     = 2;

  // Number of bus bytes needed to carry a register of the given width.
  function automatic int unsigned bytes_of(input int unsigned width);
    return (width + 32'd7) / 32'd8;
  endfunction

endpackage

// File: rtl/fpga_regs_bank_if.sv
// Byte-bus fabric between a command master and the register bank.
interface fpga_regs_bank_if #(
  parameter int unsigned NUM_REGS = 9
);
  logic [7:0]            master_data;
  logic                  master_sof;
  logic [NUM_REGS-1:0]   valid_bus;
  logic [NUM_REGS-1:0]   rdreq_bus;
  logic [NUM_REGS-1:0]   have_msg_bus;
  logic [8*NUM_REGS-1:0] slave_data_bus;
  logic [8*NUM_REGS-1:0] len_bus;

  modport master (
    output master_data, master_sof, valid_bus, rdreq_bus,
    input  have_msg_bus, slave_data_bus, len_bus
  );

  modport slave (
    input  master_data, master_sof, valid_bus, rdreq_bus,
    output have_msg_bus, slave_data_bus, len_bus
  );
endinterface

// File: rtl/fpga_regs_bank_channel.sv
// One register channel: MSB-first byte assembly, atomic commit and,
// when FPGA_REGS_READBACK_EN is defined, a FWFT readback of the stored bytes.
module fpga_reg_channel
  import fpga_regs_pkg::*;
#(
  parameter int unsigned      REG_W    = 8,
  parameter logic [REG_W-1:0] INIT_VAL = '0
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [7:0]       master_data_i,
  input  logic             master_sof_i,
  input  logic             valid_i,
  input  logic             rdreq_i,
  output logic             have_msg_o,
  output logic [7:0]       slave_data_o,
  output logic [7:0]       len_o,
  output logic [REG_W-1:0] reg_o,
  output logic             commit_o
);

  localparam int unsigned     BYTES = bytes_of(REG_W);
  localparam int unsigned     SH_W  = 8 * BYTES;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BYTES - 1);

  logic [SH_W-1:0]  shadow_q, shadow_d;
  logic [SH_W+7:0]  cat;
  logic [CNT_W-1:0] wr_cnt_q, cnt_eff;
  logic [REG_W-1:0] reg_q;
  logic             commit_q;
  logic             commit_now;

  // Next shadow contents and commit decision; SOF restarts the frame at byte 0.
  always_comb begin
    cat        = {shadow_q, master_data_i};
    shadow_d   = cat[SH_W-1:0];
    cnt_eff    = master_sof_i ? '0 : wr_cnt_q;
    commit_now = valid_i && (cnt_eff == LAST);
  end

  // Byte assembly and atomic register commit.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      shadow_q <= '0;
      wr_cnt_q <= '0;
      reg_q    <= INIT_VAL;
      commit_q <= 1'b0;
    end else begin
      commit_q <= 1'b0;
      if (valid_i) begin
        shadow_q <= shadow_d;
        if (commit_now) begin
          reg_q    <= cat[REG_W-1:0];
          wr_cnt_q <= '0;
          commit_q <= 1'b1;
        end else begin
          wr_cnt_q <= cnt_eff + 1'b1;
        end
      end else if (master_sof_i) begin
        wr_cnt_q <= '0;
      end
    end
  end

  assign reg_o    = reg_q;
  assign commit_o = commit_q;

`ifdef FPGA_REGS_READBACK_EN
  logic [SH_W-1:0]  snap_q;
  logic [CNT_W-1:0] rd_ptr_q;
  logic             have_q;

  // Readback snapshot; a commit overrides a coincident pop.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      snap_q   <= '0;
      rd_ptr_q <= '0;
      have_q   <= 1'b0;
    end else if (commit_now) begin
      snap_q   <= shadow_d;
      rd_ptr_q <= '0;
      have_q   <= 1'b1;
    end else if (rdreq_i && have_q) begin
      if (rd_ptr_q == LAST) begin
        rd_ptr_q <= '0;
        have_q   <= 1'b0;
      end else begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  // First-word-fall-through view of the snapshot, MSB byte first.
  always_comb begin
    slave_data_o = '0;
    for (int unsigned i = 0; i < BYTES; i++) begin
      if (rd_ptr_q == CNT_W'(i)) slave_data_o = snap_q[(BYTES-1-i)*8 +: 8];
    end
    len_o      = have_q ? (8'(BYTES) - 8'(rd_ptr_q)) : '0;
    have_msg_o = have_q;
  end
`else
  // Readback path not built.
  always_comb begin
    slave_data_o = '0;
    len_o        = '0;
    have_msg_o   = 1'b0;
  end
`endif

endmodule

// File: rtl/fpga_regs_bank.sv
// Parametrised control-register bank on the master/slave byte-bus fabric.
// Optional readback path enabled by defining FPGA_REGS_READBACK_EN.
module fpga_regs_bank
  import fpga_regs_pkg::*;
#(
  parameter int unsigned               NUM_REGS = 9,
  parameter int unsigned               REG_W    = 8,
  parameter logic [NUM_REGS*REG_W-1:0] INIT     = '0
) (
  input  logic                      clk,
  input  logic                      n_rst,
  fpga_regs_bank_if.slave           bus,
  output logic [NUM_REGS*REG_W-1:0] regs_bus,
  output logic [NUM_REGS-1:0]       commit_bus
);

  logic [NUM_REGS-1:0]   have_msg;
  logic [8*NUM_REGS-1:0] slave_data;
  logic [8*NUM_REGS-1:0] len;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_ch
    fpga_reg_channel #(
      .REG_W   (REG_W),
      .INIT_VAL(INIT[g*REG_W +: REG_W])
    ) u_ch (
      .clk          (clk),
      .n_rst        (n_rst),
      .master_data_i(bus.master_data),
      .master_sof_i (bus.master_sof),
      .valid_i      (bus.valid_bus[g]),
      .rdreq_i      (bus.rdreq_bus[g]),
      .have_msg_o   (have_msg[g]),
      .slave_data_o (slave_data[8*g +: 8]),
      .len_o        (len[8*g +: 8]),
      .reg_o        (regs_bus[g*REG_W +: REG_W]),
      .commit_o     (commit_bus[g])
    );
  end

  // Publish per-channel readback state onto the fabric.
  always_comb begin
    bus.have_msg_bus   = have_msg;
    bus.slave_data_bus = slave_data;
    bus.len_bus        = len;
  end

endmodule

// File: tb/tb_fpga_regs_bank.sv
// Directed bench for fpga_regs_bank: a 12-bit bank and an 8-bit bank.
// Readback expectations follow whether FPGA_REGS_READBACK_EN is defined.
module tb_fpga_regs_bank;
  localparam int unsigned N = 9;
  localparam logic [N*12-1:0] INIT_A = {12'h888, 12'h777, 12'h666, 12'h555,
                                        12'h444, 12'h333, 12'h222, 12'h111, 12'hABC};

  logic clk, n_rst;
  logic [N*12-1:0] regsA, expA;
  logic [N*8-1:0]  regsB, expB;
  logic [N-1:0]    commitA, commitB;
  int unsigned total = 0, bad = 0;

  fpga_regs_bank_if #(.NUM_REGS(N)) ifA ();
  fpga_regs_bank_if #(.NUM_REGS(N)) ifB ();

  fpga_regs_bank #(.NUM_REGS(N), .REG_W(12), .INIT(INIT_A)) dutA (
    .clk(clk), .n_rst(n_rst), .bus(ifA), .regs_bus(regsA), .commit_bus(commitA));
  fpga_regs_bank #(.NUM_REGS(N), .REG_W(8), .INIT('0)) dutB (
    .clk(clk), .n_rst(n_rst), .bus(ifB), .regs_bus(regsB), .commit_bus(commitB));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned ch;
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [11:0] exp;
  } vec_t;
  vec_t vt[5];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wrA(input int unsigned ch, input logic [7:0] d, input logic sof);
    ifA.valid_bus   = N'(1) << ch;
    ifA.master_data = d;
    ifA.master_sof  = sof;
    step();
    ifA.valid_bus  = '0;
    ifA.master_sof = 1'b0;
  endtask

  task automatic rdA(input int unsigned ch);
    ifA.rdreq_bus = N'(1) << ch;
    step();
    ifA.rdreq_bus = '0;
  endtask

  initial begin
    vt[0] = '{ch: 2, b0: 8'hF5, b1: 8'h3C, exp: 12'h53C};
    vt[1] = '{ch: 0, b0: 8'h12, b1: 8'h34, exp: 12'h234};
    vt[2] = '{ch: 8, b0: 8'hFF, b1: 8'hFF, exp: 12'hFFF};
    vt[3] = '{ch: 5, b0: 8'h00, b1: 8'h00, exp: 12'h000};
    vt[4] = '{ch: 3, b0: 8'hA0, b1: 8'h01, exp: 12'h001};

    n_rst = 1'b0;
    ifA.master_data = '0; ifA.master_sof = 1'b0; ifA.valid_bus = '0; ifA.rdreq_bus = '0;
    ifB.master_data = '0; ifB.master_sof = 1'b0; ifB.valid_bus = '0; ifB.rdreq_bus = '0;
    expA = INIT_A;
    expB = '0;
    step(); step();
    n_rst = 1'b1;
    step();

    // Reset state
    chk("rst_regsA", regsA, expA);
    chk("rst_regsB", regsB, expB);
    chk("rst_have", ifA.have_msg_bus, '0);
    chk("rst_len", ifA.len_bus, '0);
    chk("rst_commit", commitA, '0);

    // Two-byte commits with truncation
    for (int i = 0; i < 5; i++) begin
      wrA(vt[i].ch, vt[i].b0, 1'b0);
      chk("vec_b0_commit", commitA, '0);
      chk("vec_b0_regs", regsA, expA);
      wrA(vt[i].ch, vt[i].b1, 1'b0);
      expA[vt[i].ch*12 +: 12] = vt[i].exp;
      chk("vec_b1_regs", regsA, expA);
      chk("vec_b1_commit", commitA, N'(1) << vt[i].ch);
      step();
      chk("vec_pulse_end", commitA, '0);
    end

    // Readback drain on channel 2
    wrA(2, 8'hF5, 1'b0);
    wrA(2, 8'h3C, 1'b0);
`ifdef FPGA_REGS_READBACK_EN
    chk("rb_have", ifA.have_msg_bus[2], 1'b1);
    chk("rb_len0", ifA.len_bus[16 +: 8], 8'd2);
    chk("rb_data0", ifA.slave_data_bus[16 +: 8], 8'hF5);
    rdA(2);
    chk("rb_data1", ifA.slave_data_bus[16 +: 8], 8'h3C);
    chk("rb_len1", ifA.len_bus[16 +: 8], 8'd1);
    rdA(2);
    chk("rb_have_drained", ifA.have_msg_bus[2], 1'b0);
    chk("rb_len_drained", ifA.len_bus[16 +: 8], 8'd0);
    rdA(2);
    chk("rb_have_extra", ifA.have_msg_bus, '0);
    chk("rb_len_extra", ifA.len_bus, '0);
`else
    chk("nrb_have", ifA.have_msg_bus, '0);
    rdA(2);
    chk("nrb_data", ifA.slave_data_bus, '0);
    chk("nrb_len", ifA.len_bus, '0);
`endif
    chk("rb_regs", regsA, expA);

    // Start-of-frame abort on channel 1
    wrA(1, 8'h12, 1'b0);
    chk("sof_no_commit0", commitA, '0);
    chk("sof_regs_hold0", regsA, expA);
    wrA(1, 8'h34, 1'b1);
    chk("sof_no_commit1", commitA, '0);
    chk("sof_regs_hold1", regsA, expA);
    wrA(1, 8'h56, 1'b0);
    expA[12 +: 12] = 12'h456;
    chk("sof_regs", regsA, expA);
    chk("sof_commit", commitA, N'(1) << 1);

    // SOF without valid mid-frame on channel 7
    wrA(7, 8'h99, 1'b0);
    ifA.master_sof = 1'b1;
    step();
    ifA.master_sof = 1'b0;
    chk("sof_idle_commit", commitA, '0);
    wrA(7, 8'hAB, 1'b0);
    chk("sof_idle_b0", commitA, '0);
    wrA(7, 8'hCD, 1'b0);
    expA[7*12 +: 12] = 12'hBCD;
    chk("sof_idle_regs", regsA, expA);

    // Commit coincident with rdreq on 8-bit bank channel 4
    ifB.valid_bus = N'(1) << 4; ifB.master_data = 8'h11;
    step();
    ifB.valid_bus = '0;
    expB[4*8 +: 8] = 8'h11;
    chk("b_commit11", regsB, expB);
    chk("b_commit11_pulse", commitB, N'(1) << 4);
    ifB.valid_bus = N'(1) << 4; ifB.master_data = 8'h22; ifB.rdreq_bus = N'(1) << 4;
    step();
    ifB.valid_bus = '0; ifB.rdreq_bus = '0;
    expB[4*8 +: 8] = 8'h22;
    chk("b_commit22", regsB, expB);
`ifdef FPGA_REGS_READBACK_EN
    chk("b_race_data", ifB.slave_data_bus[32 +: 8], 8'h22);
    chk("b_race_have", ifB.have_msg_bus[4], 1'b1);
    chk("b_race_len", ifB.len_bus[32 +: 8], 8'd1);
`else
    chk("b_race_have", ifB.have_msg_bus, '0);
`endif

    // Broadcast 0x7E to every channel of the 8-bit bank
    ifB.valid_bus = '1; ifB.master_data = 8'h7E;
    step();
    ifB.valid_bus = '0;
    expB = {N{8'h7E}};
    chk("b_bcast_regs", regsB, expB);
    chk("b_bcast_commit", commitB, {N{1'b1}});
`ifdef FPGA_REGS_READBACK_EN
    ifB.rdreq_bus = '1;
    step();
    ifB.rdreq_bus = '0;
    chk("b_bcast_drain", ifB.have_msg_bus, '0);
`else
    for (int k = 0; k < 12; k++) begin
      ifB.rdreq_bus = N'($urandom_range(0, (1 << N) - 1));
      step();
      chk("b_rand_have", ifB.have_msg_bus, '0);
      chk("b_rand_data", ifB.slave_data_bus, '0);
      chk("b_rand_len", ifB.len_bus, '0);
    end
    ifB.rdreq_bus = '0;
`endif
    chk("b_bcast_hold", regsB, expB);

    // Asynchronous reset mid-frame
    wrA(6, 8'h55, 1'b0);
    #2 n_rst = 1'b0;
    #1;
    expA = INIT_A;
    expB = '0;
    chk("arst_regsA", regsA, expA);
    chk("arst_regsB", regsB, expB);
    chk("arst_have", ifB.have_msg_bus, '0);
    @(negedge clk);
    n_rst = 1'b1;
    step();
    wrA(6, 8'h66, 1'b0);
    chk("arst_no_commit", commitA, '0);
    wrA(6, 8'h77, 1'b0);
    expA[6*12 +: 12] = 12'h677;
    chk("arst_regs_after", regsA, expA);
    chk("arst_commit", commitA, N'(1) << 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
